// File: rtl/pipe_defs.sv
// Shared definitions for the EXE->MEM pipeline register.
// Purpose : default field widths of the EXE/MEM bundle and its packed bit
//           layout, so every file agrees on where each field sits.
// Layout  : MSB [ wb_en | mem_read_en | mem_write_en | alu_res | val_rm | dest ] LSB
//           With the default widths this is 3 + 32 + 32 + 4 = 71 bits.
package pipe_defs;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEST_W = 4;
  localparam int CTRL_W     = 3;

  // Bit index of each control flag within the control field.
  localparam int CTRL_WR = 0;
  localparam int CTRL_RD = 1;
  localparam int CTRL_WB = 2;

  function automatic int bundle_w(input int data_w, input int dest_w);
    return CTRL_W + 2 * data_w + dest_w;
  endfunction

  function automatic int rm_lsb(input int data_w, input int dest_w);
    return dest_w + 0 * data_w;
  endfunction

  function automatic int alu_lsb(input int data_w, input int dest_w);
    return dest_w + data_w;
  endfunction

  function automatic int ctrl_lsb(input int data_w, input int dest_w);
    return dest_w + 2 * data_w;
  endfunction

  localparam int DEF_BUNDLE_W = bundle_w(DEF_DATA_W, DEF_DEST_W);

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline slot: a valid bit plus payload register.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   load_i           capture valid_i/data_i on this edge
//   clear_i          empty the slot (wins over load_i)
//   valid_i, data_i  next contents when loading
//   valid_o, data_o  registered contents
// A cleared slot zeroes its payload, so its control flags read as 0.
module pipe_skid_slot #(
  parameter int W = 71
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= {W{1'b0}};
    end else if (load_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end else begin
      valid_q <= valid_q;
      data_q  <= data_q;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/exe_mem_reg.sv
// EXE->MEM pipeline register with a one-entry skid buffer.
// Purpose : holds the EXE result bundle for the MEM stage. A busy memory can
//           freeze the MEM side combinationally; the stall back to EXE is the
//           skid slot's valid flop, so it is registered.
// Ports:
//   clk, rst, flush, freeze              control (rst sync, active high)
//   in_valid + EXE bundle fields         upstream instruction
//   stall_up                             EXE must hold its instruction
//   out_valid + MEM bundle fields        downstream instruction (flop outputs)
//   freeze_cycles                        saturating count of frozen valid cycles
module exe_mem_reg
  import pipe_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEST_W = DEF_DEST_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  input  logic              wb_en_in,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              stall_up,
  output logic              out_valid,
  output logic              wb_en,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] val_rm,
  output logic [DEST_W-1:0] dest,
  output logic [CNT_W-1:0]  freeze_cycles
);

  localparam int BW    = bundle_w(DATA_W, DEST_W);
  localparam int RM_L  = rm_lsb(DATA_W, DEST_W);
  localparam int ALU_L = alu_lsb(DATA_W, DEST_W);
  localparam int CTL_L = ctrl_lsb(DATA_W, DEST_W);

  logic          accept_s;
  logic [BW-1:0] in_bundle_s;
  logic          main_valid_s, skid_valid_s;
  logic [BW-1:0] main_data_s, skid_data_s;
  logic          main_load_d, main_clr_d, main_vin_d;
  logic [BW-1:0] main_din_d;
  logic          skid_load_d, skid_clr_d, skid_vin_d;
  logic [BW-1:0] skid_din_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign accept_s = in_valid & ~skid_valid_s;

  // Controls of a non-accepted input are masked so a loaded bubble never
  // carries stray enables.
  assign in_bundle_s = {wb_en_in & accept_s, mem_read_en_in & accept_s,
                        mem_write_en_in & accept_s, alu_res_in, val_rm_in, dest_in};

  // Steering between input, main slot and skid slot.
  always_comb begin
    main_load_d = 1'b0;
    main_clr_d  = 1'b0;
    main_vin_d  = 1'b0;
    main_din_d  = in_bundle_s;
    skid_load_d = 1'b0;
    skid_clr_d  = 1'b0;
    skid_vin_d  = 1'b0;
    skid_din_d  = in_bundle_s;
    if (flush) begin
      main_clr_d = 1'b1;
      skid_clr_d = 1'b1;
    end else if (freeze && main_valid_s) begin
      // MEM is blocked: main holds, a newly accepted input parks in skid.
      if (accept_s) begin
        skid_load_d = 1'b1;
        skid_vin_d  = 1'b1;
      end else begin
        skid_load_d = 1'b0;
      end
    end else if (skid_valid_s) begin
      // Skid is older than anything upstream; it drains first.
      main_load_d = 1'b1;
      main_vin_d  = 1'b1;
      main_din_d  = skid_data_s;
      skid_clr_d  = 1'b1;
    end else begin
      // Normal flow, or an empty main stage that is frozen but not blocking.
      main_load_d = 1'b1;
      main_vin_d  = accept_s;
      main_din_d  = in_bundle_s;
    end
  end

  pipe_skid_slot #(.W(BW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load_d),
    .clear_i (main_clr_d),
    .valid_i (main_vin_d),
    .data_i  (main_din_d),
    .valid_o (main_valid_s),
    .data_o  (main_data_s)
  );

  pipe_skid_slot #(.W(BW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load_d),
    .clear_i (skid_clr_d),
    .valid_i (skid_vin_d),
    .data_i  (skid_din_d),
    .valid_o (skid_valid_s),
    .data_o  (skid_data_s)
  );

  // Freeze-cycle counter next state: saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (freeze && main_valid_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Freeze-cycle counter register; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_up      = skid_valid_s;
  assign out_valid     = main_valid_s;
  assign wb_en         = main_data_s[CTL_L + CTRL_WB];
  assign mem_read_en   = main_data_s[CTL_L + CTRL_RD];
  assign mem_write_en  = main_data_s[CTL_L + CTRL_WR];
  assign alu_res       = main_data_s[ALU_L +: DATA_W];
  assign val_rm        = main_data_s[RM_L +: DATA_W];
  assign dest          = main_data_s[0 +: DEST_W];
  assign freeze_cycles = cnt_q;

endmodule

// File: tb/tb_exe_mem_reg.sv
module tb_exe_mem_reg;

  typedef struct packed {
    logic        wb;
    logic        rd;
    logic        wr;
    logic [31:0] alu;
    logic [31:0] rm;
    logic [3:0]  dest;
  } bun_t;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, in_valid;
  logic        wb_en_in, mem_read_en_in, mem_write_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        stall_up, out_valid, wb_en, mem_read_en, mem_write_en;
  logic [31:0] alu_res, val_rm;
  logic [3:0]  dest;
  logic [3:0]  freeze_cycles;

  int   errors = 0;
  int   checks = 0;
  bun_t exp_q[$];

  bun_t A, B, C, D, Z;

  exe_mem_reg #(.DATA_W(32), .DEST_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .in_valid(in_valid),
    .wb_en_in(wb_en_in), .mem_read_en_in(mem_read_en_in),
    .mem_write_en_in(mem_write_en_in), .alu_res_in(alu_res_in),
    .val_rm_in(val_rm_in), .dest_in(dest_in), .stall_up(stall_up),
    .out_valid(out_valid), .wb_en(wb_en), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .alu_res(alu_res), .val_rm(val_rm),
    .dest(dest), .freeze_cycles(freeze_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented MEM bundle against the oldest expected
  // entry; an entry retires on a cycle where it is presented and not frozen.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 80'd1, 80'd0);
      end else begin
        chk("out_bundle", {wb_en, mem_read_en, mem_write_en, alu_res, val_rm, dest},
            exp_q[0]);
        if (!freeze) void'(exp_q.pop_front());
      end
    end else begin
      chk("bubble_enables", {wb_en, mem_read_en, mem_write_en}, 80'd0);
    end
  end

  task automatic drive(input bit v, input bun_t b);
    in_valid        = v;
    wb_en_in        = b.wb;
    mem_read_en_in  = b.rd;
    mem_write_en_in = b.wr;
    alu_res_in      = b.alu;
    val_rm_in       = b.rm;
    dest_in         = b.dest;
  endtask

  // One cycle: drive, optionally expect acceptance, check registered state.
  task automatic step(input bit v, input bun_t b, input bit fr, input bit fl,
                      input bit acc, input bit ex_stall, input bit ex_ov);
    drive(v, b);
    freeze = fr;
    flush  = fl;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    chk("stall_up", stall_up, ex_stall);
    chk("out_valid", out_valid, ex_ov);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 80'd0);
    chk({tag, "_enables"}, {wb_en, mem_read_en, mem_write_en}, 80'd0);
    chk({tag, "_data"}, {alu_res, val_rm, dest}, 80'd0);
    chk({tag, "_stall"}, stall_up, 80'd0);
    chk({tag, "_cnt"}, freeze_cycles, 80'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    A = '{wb: 1'b1, rd: 1'b1, wr: 1'b0, alu: 32'h100, rm: 32'h0, dest: 4'd3};
    B = '{wb: 1'b0, rd: 1'b0, wr: 1'b1, alu: 32'h104, rm: 32'hDEADBEEF, dest: 4'd5};
    C = '{wb: 1'b1, rd: 1'b0, wr: 1'b0, alu: 32'h200, rm: 32'h11, dest: 4'd7};
    D = '{wb: 1'b1, rd: 1'b0, wr: 1'b0, alu: 32'h300, rm: 32'h0, dest: 4'd9};
    Z = '0;

    // Reset with a valid input present.
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    drive(1'b1, A);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Back-to-back stream.
    step(1, A, 0, 0, 1, 0, 0);
    step(1, B, 0, 0, 1, 0, 1);
    step(0, Z, 0, 0, 0, 0, 1);
    step(0, Z, 0, 0, 0, 0, 0);

    // Freeze with skid: A held, B parked, C held upstream.
    step(1, A, 0, 0, 1, 0, 0);
    step(1, B, 1, 0, 1, 0, 1);
    step(1, C, 1, 0, 0, 1, 1);
    step(1, C, 1, 0, 0, 1, 1);
    step(1, C, 0, 0, 0, 1, 1);
    step(1, C, 0, 0, 1, 0, 1);
    step(0, Z, 0, 0, 0, 0, 1);
    chk("freeze_cycles_3", freeze_cycles, 80'd3);
    step(0, Z, 0, 0, 0, 0, 0);

    // Freeze on an empty stage loads directly.
    step(1, A, 1, 0, 1, 0, 0);
    step(0, Z, 0, 0, 0, 0, 1);
    chk("freeze_cycles_empty", freeze_cycles, 80'd3);
    step(0, Z, 0, 0, 0, 0, 0);

    // Flush with A in main, B in skid, C presented.
    step(1, A, 0, 0, 1, 0, 0);
    step(1, B, 1, 0, 1, 0, 1);
    step(1, C, 1, 1, 0, 1, 1);
    step(0, Z, 0, 0, 0, 0, 0);
    step(0, Z, 0, 0, 0, 0, 0);
    chk("freeze_cycles_flush", freeze_cycles, 80'd5);

    // Saturation: 20 frozen valid cycles on a 4-bit counter.
    step(1, D, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, Z, 1, 0, 0, 0, 1);
    chk("freeze_cycles_sat", freeze_cycles, 80'd15);
    step(0, Z, 0, 0, 0, 0, 1);
    chk("freeze_cycles_hold", freeze_cycles, 80'd15);

    // Reset while an instruction sits in skid under freeze.
    step(1, A, 0, 0, 1, 0, 0);
    step(1, B, 1, 0, 1, 0, 1);
    drive(1'b1, C);
    rst = 1'b1; freeze = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("reset_skid");
    rst = 1'b0; freeze = 1'b0;
    drive(1'b0, Z);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_mem_reg.md
Name: exe_mem_reg

Overview:
- EXE→MEM pipeline register of the ARM pipeline. Captures the EXE-stage result bundle and presents it to the MEM stage (data memory address, store data, read/write enables, write-back controls).
- Includes a one-entry skid buffer, so the stall driven back to EXE is a registered signal while the MEM side can be frozen combinationally by a busy memory.
- Includes a saturating counter of cycles spent frozen, for lab performance measurement.

Parameters:
- DATA_W, 32, width of alu_res and val_rm.
- DEST_W, 4, register-file destination index width.
- CNT_W, 16, width of the freeze-cycle counter.

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discard all held and incoming instructions this cycle.
- freeze  input  1  MEM stage cannot accept; hold output bundle.
- in_valid  input  1  EXE presents an instruction.
- wb_en_in, mem_read_en_in, mem_write_en_in  input  1 each  EXE control bits.
- alu_res_in  input  DATA_W  ALU result / memory address.
- val_rm_in  input  DATA_W  store data.
- dest_in  input  DEST_W  write-back register index.
- stall_up  output  1  registered; when 1, EXE must hold its instruction.
- out_valid  output  1  MEM bundle is a real instruction.
- wb_en, mem_read_en, mem_write_en  output  1 each  controls to MEM, forced 0 when out_valid=0.
- alu_res, val_rm  output  DATA_W  to data memory address / write data.
- dest  output  DEST_W  to MEM/WB.
- freeze_cycles  output  CNT_W  count of cycles with freeze=1 and out_valid=1, saturating.

Behaviour:
- State: main register (valid + bundle), skid register (valid + bundle), counter. All outputs are direct flop outputs; no combinational input→output path.
- Reset: all valids 0, every bundle field 0, stall_up 0, freeze_cycles 0. Reset overrides flush and freeze, including when an instruction is in the skid register.
- Priority: rst > flush > freeze > normal.
- Upstream acceptance: the input is taken iff in_valid=1 and stall_up=0 in that cycle. stall_up equals the skid register's valid bit.
- Normal (freeze=0):
  - If skid is valid, main ← skid and skid is cleared. The input cannot be valid and accepted in this cycle, because stall_up=1.
  - Otherwise main ← input if accepted, else main becomes a bubble.
- Freeze with main valid: main holds every field unchanged. An accepted input goes into skid. No input is ever lost or duplicated.
- Freeze with main empty: main loads the accepted input directly, since an empty stage is not blocking.
- Flush: main and skid valid are cleared and their controls zeroed; the input of that cycle is dropped; stall_up=0 next cycle. Flush during freeze is honoured.
- Bubbles: wb_en, mem_read_en and mem_write_en are 0 whenever the corresponding valid is 0. Data fields of a bubble may hold stale values.
- Latency: 1 cycle from accepted input to out_valid when not frozen. Maximum occupancy is 2 instructions.
- freeze_cycles:
  - Increments by 1 on each edge where freeze=1 and out_valid=1.
  - Saturates at all-ones and never wraps.
  - Cleared only by rst; flush does not clear it.
- Ordering: instructions leave in arrival order; the skid entry is always older than any later input.

Decomposition:
- Shared package/header `pipe_defs`:
  - the EXE/MEM bundle field widths (DATA_W, DEST_W);
  - the bundle bit-layout constants for packing the 71-bit bundle (3 controls + 2×DATA_W + DEST_W).
- One natural sub-module, `pipe_skid_slot`: a valid+payload register with load/hold/clear. Instantiate it twice (main, skid); the top holds the steering logic and the counter.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 → all outputs 0, stall_up=0, freeze_cycles=0.
- Stream: back-to-back inputs A(alu_res=0x100, wb_en=1, mem_read_en=1, dest=3) then B(alu_res=0x104, mem_write_en=1, val_rm=0xDEADBEEF) with freeze=0 → each appears on outputs exactly one cycle after issue; stall_up stays 0.
- Freeze with skid:
  - Setup: A in main; freeze=1 for 3 cycles while B is presented.
  - Required: A held unchanged; B captured into skid; stall_up=1 from the next cycle; C held by EXE.
  - On release: B appears, then C. freeze_cycles=3.
- Freeze on empty stage: out_valid=0, freeze=1, input A → A is loaded into main; stall_up stays 0.
- Flush: A in main, B in skid, C presented, flush=1 → next cycle out_valid=0, all enables 0, stall_up=0; C never appears.
- Counter saturation: with CNT_W=4, hold freeze=1 with main valid for 20 cycles → freeze_cycles stops at 15.
